// File: rtl/id_decode_stage_if.sv
// Bus bundle between the IF/ID register, the write-back port, the EX hazard
// inputs and the RV32I decode stage. The decode stage attaches through the slave modport.
interface id_decode_stage_if #(
    parameter int XLEN = 32
);
    // Handshake: the IF/ID entry in instr is consumed on a cycle where instr_valid=1
    // and stall=0. dec_valid marks that cycle for the ID/EX register. stall=1 asks
    // upstream to hold PC and IF/ID and causes a bubble to be inserted downstream.
    logic            instr_valid;
    logic [31:0]     instr;
    logic            wb_en;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ex_mem_read;
    logic [4:0]      ex_rd_addr;

    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            dec_valid;
    logic            illegal;
    logic            stall;

    modport master (
        output instr_valid, instr, wb_en, wb_addr, wb_data, ex_mem_read, ex_rd_addr,
        input  rd_addr, rs1_data, rs2_data, funct3, funct7, imm, dec_valid, illegal, stall
    );

    modport slave (
        input  instr_valid, instr, wb_en, wb_addr, wb_data, ex_mem_read, ex_rd_addr,
        output rd_addr, rs1_data, rs2_data, funct3, funct7, imm, dec_valid, illegal, stall
    );
endinterface

// File: rtl/id_decode_stage.sv
// RV32I instruction-decode stage: register file, field extraction, immediate
// generation and load-use hazard detection. Optional macro: ID_WB_BYPASS_EN.
module id_decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    id_decode_stage_if.slave     bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [XLEN-1:0] rf [NREGS];

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] imm_c;
    logic            known_op;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            hazard;

    assign instr    = bus.instr;
    assign opcode   = instr[6:0];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    // Entry 0 is never written, so x0 stays zero; reads still mask it explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_comb begin
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        if (rs1_addr != 5'd0) begin
            bus.rs1_data = rf[rs1_addr];
        end
        if (rs2_addr != 5'd0) begin
            bus.rs2_data = rf[rs2_addr];
        end
`ifdef ID_WB_BYPASS_EN
        // Write-first: a same-cycle write-back is forwarded; suppressed in reset
        // because the write itself is discarded then.
        if (!rst && bus.wb_en && (bus.wb_addr != 5'd0)) begin
            if (bus.wb_addr == rs1_addr) begin
                bus.rs1_data = bus.wb_data;
            end
            if (bus.wb_addr == rs2_addr) begin
                bus.rs2_data = bus.wb_data;
            end
        end
`endif
    end

    always_comb begin
        imm_c    = '0;
        known_op = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                imm_c = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                imm_c    = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                imm_c    = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                uses_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_c    = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
                uses_rs1 = 1'b0;
            end
            OP_JAL: begin
                imm_c    = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                uses_rs1 = 1'b0;
            end
            OP_REG: begin
                uses_rs2 = 1'b1;
            end
            OP_FENCE: begin
                imm_c = '0;
            end
            default: begin
                known_op = 1'b0;
            end
        endcase
    end

    // One-cycle load-use stall: next cycle the load has left EX and ex_mem_read drops.
    assign hazard = bus.ex_mem_read && (bus.ex_rd_addr != 5'd0) &&
                    ((uses_rs1 && (bus.ex_rd_addr == rs1_addr)) ||
                     (uses_rs2 && (bus.ex_rd_addr == rs2_addr)));

    assign bus.rd_addr   = instr[11:7];
    assign bus.funct3    = instr[14:12];
    assign bus.funct7    = instr[31:25];
    assign bus.imm       = imm_c;
    assign bus.stall     = bus.instr_valid && hazard && !rst;
    assign bus.illegal   = bus.instr_valid && !known_op && !rst;
    assign bus.dec_valid = bus.instr_valid && !bus.stall && !rst;
endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: hand-computed vectors for register file,
// immediates, hazards, write/read ordering and reset.
module tb_id_decode_stage;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    id_decode_stage_if #(.XLEN(32)) bus ();

    id_decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a new instruction away from the rising edge and let it settle.
    task automatic drive_instr(input logic valid, input logic [31:0] word);
        @(negedge clk);
        bus.instr_valid = valid;
        bus.instr       = word;
        #1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        @(negedge clk);
        bus.wb_en   = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst             = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0000_007F;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = '0;
        bus.ex_mem_read = 1'b1;
        bus.ex_rd_addr  = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dec_valid", {31'd0, bus.dec_valid}, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check("rst_imm", bus.imm, 32'd0);
        // add x4,x3,x2 with a load to x3 in EX: no stall while in reset
        bus.ex_rd_addr = 5'd3;
        bus.instr      = 32'h0021_8233;
        #1;
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_rs1", bus.rs1_data, 32'd0);
        @(negedge clk);
        rst             = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd_addr  = 5'd0;
        bus.instr_valid = 1'b0;

        // x5 = 0xDEADBEEF, then add x1,x5,x0
        wb_write(5'd5, 32'hDEAD_BEEF);
        drive_instr(1'b1, 32'h0002_80B3);
        check("add_rs1", bus.rs1_data, 32'hDEAD_BEEF);
        check("add_rs2", bus.rs2_data, 32'd0);
        check("add_rd", {27'd0, bus.rd_addr}, 32'd1);
        check("add_f3", {29'd0, bus.funct3}, 32'd0);
        check("add_f7", {25'd0, bus.funct7}, 32'd0);
        check("add_imm", bus.imm, 32'd0);
        check("add_valid", {31'd0, bus.dec_valid}, 32'd1);
        check("add_illegal", {31'd0, bus.illegal}, 32'd0);

        // write to x0 is discarded; x5 untouched
        wb_write(5'd0, 32'h1234_5678);
        drive_instr(1'b1, 32'h0000_00B3);
        check("x0_rs1", bus.rs1_data, 32'd0);
        check("x0_rs2", bus.rs2_data, 32'd0);
        drive_instr(1'b1, 32'h0002_80B3);
        check("x5_kept", bus.rs1_data, 32'hDEAD_BEEF);

        // immediates
        drive_instr(1'b1, 32'hFFF0_0093);
        check("addi_imm", bus.imm, 32'hFFFF_FFFF);
        drive_instr(1'b1, 32'hFE20_AE23);
        check("sw_imm", bus.imm, 32'hFFFF_FFFC);
        check("sw_f3", {29'd0, bus.funct3}, 32'd2);
        drive_instr(1'b1, 32'h0020_8463);
        check("beq_imm", bus.imm, 32'h0000_0008);
        drive_instr(1'b1, 32'hABCD_E1B7);
        check("lui_imm", bus.imm, 32'hABCD_E000);
        check("lui_rd", {27'd0, bus.rd_addr}, 32'd3);
        drive_instr(1'b1, 32'h801F_F06F);
        check("jal_imm", bus.imm, 32'hFFFF_F800);

        // load-use hazards with a load to x3 in EX
        bus.ex_mem_read = 1'b1;
        bus.ex_rd_addr  = 5'd3;
        drive_instr(1'b1, 32'h0021_8233);
        check("lu_rs1_stall", {31'd0, bus.stall}, 32'd1);
        check("lu_rs1_valid", {31'd0, bus.dec_valid}, 32'd0);
        @(negedge clk);
        bus.ex_mem_read = 1'b0;
        #1;
        check("lu_after_stall", {31'd0, bus.stall}, 32'd0);
        check("lu_after_valid", {31'd0, bus.dec_valid}, 32'd1);
        bus.ex_mem_read = 1'b1;
        // lui x5,0x18 has 3 in its rs1 field but does not read rs1
        drive_instr(1'b1, 32'h0001_82B7);
        check("lui_no_stall", {31'd0, bus.stall}, 32'd0);
        check("lui_valid", {31'd0, bus.dec_valid}, 32'd1);
        drive_instr(1'b1, 32'h0030_A023);
        check("sw_rs2_stall", {31'd0, bus.stall}, 32'd1);
        bus.ex_rd_addr = 5'd0;
        drive_instr(1'b1, 32'h0020_0233);
        check("ex_rd_x0_stall", {31'd0, bus.stall}, 32'd0);
        bus.ex_rd_addr = 5'd3;
        drive_instr(1'b0, 32'h0021_8233);
        check("novalid_stall", {31'd0, bus.stall}, 32'd0);
        bus.ex_mem_read = 1'b0;
        bus.ex_rd_addr  = 5'd0;

        // same-cycle write/read of x7 (add x1,x7,x0)
        @(negedge clk);
        bus.wb_en       = 1'b1;
        bus.wb_addr     = 5'd7;
        bus.wb_data     = 32'h0000_0055;
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0003_80B3;
        #1;
`ifdef ID_WB_BYPASS_EN
        check("same_cycle_rd", bus.rs1_data, 32'h0000_0055);
`else
        check("same_cycle_rd", bus.rs1_data, 32'd0);
`endif
        @(negedge clk);
        bus.wb_en = 1'b0;
        #1;
        check("next_cycle_rd", bus.rs1_data, 32'h0000_0055);

        // illegal opcode
        drive_instr(1'b1, 32'h0000_007F);
        check("ill_flag", {31'd0, bus.illegal}, 32'd1);
        check("ill_imm", bus.imm, 32'd0);
        check("ill_valid", {31'd0, bus.dec_valid}, 32'd1);
        drive_instr(1'b0, 32'h0000_007F);
        check("ill_novalid", {31'd0, bus.illegal}, 32'd0);

        // reset mid-stream clears x9 and blocks an in-flight write
        wb_write(5'd9, 32'd1);
        drive_instr(1'b1, 32'h0004_80B3);
        check("x9_written", bus.rs1_data, 32'd1);
        rst         = 1'b1;
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd9;
        bus.wb_data = 32'd7;
        #1;
        check("mid_rst_x9", bus.rs1_data, 32'd0);
        check("mid_rst_valid", {31'd0, bus.dec_valid}, 32'd0);
        @(negedge clk);
        bus.wb_en = 1'b0;
        rst       = 1'b0;
        #1;
        check("post_rst_x9", bus.rs1_data, 32'd0);
        check("post_rst_x5", 32'(bus.dec_valid), 32'd1);
        drive_instr(1'b1, 32'h0002_80B3);
        check("post_rst_x5_clr", bus.rs1_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Instruction-decode stage of the pipelined RV32I core. Sits between the IF/ID register and the ID/EX register.
- Holds the 32x32 integer register file, with writes from write-back and two combinational reads.
- Extracts rd/funct3/funct7, generates the sign-extended immediate and detects load-use hazards.
- Its outputs feed the ID/EX register inputs directly.

Parameters:
- XLEN, 32, data width of registers, read data and immediate.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  the IF/ID register holds a real instruction.
- instr  input  32  instruction word from the IF/ID register.
- wb_en  input  1  write-back write enable.
- wb_addr  input  5  write-back destination register.
- wb_data  input  XLEN  write-back data.
- ex_mem_read  input  1  the instruction currently in EX is a load.
- ex_rd_addr  input  5  destination register of the instruction in EX.
- rd_addr  output  5  instr[11:7].
- rs1_data  output  XLEN  register file read, port 1.
- rs2_data  output  XLEN  register file read, port 2.
- funct3  output  3  instr[14:12].
- funct7  output  7  instr[31:25].
- imm  output  XLEN  sign-extended immediate.
- dec_valid  output  1  the outputs describe a real instruction for ID/EX to capture.
- illegal  output  1  opcode is not RV32I base.
- stall  output  1  hold PC and IF/ID; insert a bubble into ID/EX.

Behaviour:
- Reset (async assert): all registers x1..x31 clear to 0 immediately.
  - While rst is high: dec_valid=0, stall=0, illegal=0.
  - Data outputs follow combinational decode of instr with cleared registers.
  - Deassertion takes effect on the next clk edge.
- Register file write: on posedge clk when wb_en=1 and wb_addr!=0, write wb_data. Writes to x0 are discarded. Reads of x0 always return 0.
- Read latency: combinational. rs1_data=RF[instr[19:15]], rs2_data=RF[instr[24:20]].
- Same-cycle write/read (wb_addr==rs and wb_addr!=0 and wb_en=1): governed by the optional feature.
- Immediate generation, by opcode[6:0]:
  - I-type (0010011, 0000011, 1100111, 1110011): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-type (0110011) and 0001111: imm=0.
  - Any other opcode: imm=0 and illegal=instr_valid.
- Source usage:
  - uses_rs1 for every opcode except U-type and J-type.
  - uses_rs2 for R-type, S-type and B-type only.
- Load-use hazard: stall=instr_valid & ex_mem_read & (ex_rd_addr!=0) & ((uses_rs1 & ex_rd_addr==rs1) | (uses_rs2 & ex_rd_addr==rs2)).
- dec_valid = instr_valid & ~stall & ~rst.
- Stall is one cycle per load: the following cycle the load has left EX, so ex_mem_read is deasserted for it and the instruction proceeds.
- An illegal instruction still produces dec_valid=1; trap handling happens downstream.
- Reset mid-operation: register contents are lost and in-flight write-back is ignored while rst=1.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: write-first bypass. On a same-cycle write/read, rs*_data returns wb_data combinationally, so a writeback and a dependent decode may share a cycle.
- Undefined: reads return the old register value; the new value is visible from the next cycle. The hazard logic elsewhere then covers this case.

Test Plan:
- Reset, then write x5=0xDEADBEEF (wb_en=1), then decode add x1,x5,x0 -> rs1_data=0xDEADBEEF, rs2_data=0, rd_addr=1, funct3=0, funct7=0, dec_valid=1.
- Write x0=0x12345678, then read x0 -> rs1_data=0; no register changes.
- Immediate decode:
  - sw with offset -4 -> imm=0xFFFFFFFC.
  - beq with offset +8 -> imm=0x00000008.
  - lui 0xABCDE -> imm=0xABCDE000.
  - jal with offset -2048 -> imm=0xFFFFF800.
- ex_mem_read=1, ex_rd_addr=3, decode add x4,x3,x2 -> stall=1, dec_valid=0 for one cycle. Same setup with lui x3 -> stall=0.
- Same-cycle write x7=0x55 and read x7 -> 0x55 with ID_WB_BYPASS_EN defined; old value (0) without it, 0x55 the next cycle.
- Opcode 0x7F with instr_valid=1 -> illegal=1, imm=0. Assert rst mid-stream after writing x9=1 -> x9 reads 0 immediately, dec_valid=0.
